// File: rtl/rr_sched_pkg.sv
// Shared types and constants for the round-robin grant scheduler.
// HOLD_TIMEOUT_EN (top-level build macro) uses DEF_MAX_HOLD as its default hold limit.
package rr_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    GAP  = 2'd2
  } sched_state_e;

  localparam int DEF_N_REQ    = 8;
  localparam int DEF_MAX_HOLD = 16;

  // Index width for n entries; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: rotate by ptr, find first set bit, rotate back.
module rr_pick
  import rr_sched_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int IDX_W = idx_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] onehot,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  localparam logic [N_REQ-1:0] ONE_HOT_0 = N_REQ'(1'b1);

  logic [2*N_REQ-1:0] dbl_s;
  logic [N_REQ-1:0]   rot_s;
  logic [IDX_W-1:0]   enc_s;
  logic               found_s;

  // Rotate so ptr lands at bit 0, then lowest-set-bit priority encode.
  always_comb begin
    dbl_s   = {req, req} >> ptr;
    rot_s   = dbl_s[N_REQ-1:0];
    found_s = 1'b0;
    enc_s   = {IDX_W{1'b0}};
    for (int i = 0; i < N_REQ; i++) begin
      if (!found_s && rot_s[i]) begin
        found_s = 1'b1;
        enc_s   = IDX_W'(i);
      end else begin
        found_s = found_s;
      end
    end
    // N_REQ is a power of two, so the IDX_W-bit add wraps modulo N_REQ.
    idx   = found_s ? (enc_s + ptr) : {IDX_W{1'b0}};
    valid = found_s;
    if (found_s) begin
      onehot = ONE_HOT_0 << idx;
    end else begin
      onehot = {N_REQ{1'b0}};
    end
  end

endmodule

// File: rtl/rr_grant_scheduler.sv
// Round-robin scheduler with registered one-hot grant held until done, then one GAP cycle.
// Build macro HOLD_TIMEOUT_EN adds MAX_HOLD and a timeout pulse that forces release.
module rr_grant_scheduler
  import rr_sched_pkg::*;
#(
  parameter int N_REQ    = DEF_N_REQ,
`ifdef HOLD_TIMEOUT_EN
  parameter int MAX_HOLD = DEF_MAX_HOLD,
`endif
  parameter int IDX_W    = idx_w(N_REQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
`ifdef HOLD_TIMEOUT_EN
  output logic             timeout,
`endif
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid,
  output logic [IDX_W-1:0] ptr
);

  sched_state_e     state_r, state_nxt_s;
  logic [N_REQ-1:0] gnt_r, gnt_nxt_s, pick_onehot_s;
  logic [IDX_W-1:0] gnt_idx_r, gnt_idx_nxt_s, pick_idx_s;
  logic [IDX_W-1:0] ptr_r, ptr_nxt_s;
  logic             gnt_valid_r, gnt_valid_nxt_s, pick_valid_s;
  logic             release_s;

  rr_pick #(
    .N_REQ(N_REQ),
    .IDX_W(IDX_W)
  ) u_pick (
    .req   (req),
    .ptr   (ptr_r),
    .onehot(pick_onehot_s),
    .idx   (pick_idx_s),
    .valid (pick_valid_s)
  );

`ifdef HOLD_TIMEOUT_EN
  localparam int HOLD_W = idx_w(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  logic [HOLD_W-1:0] hold_cnt_r;
  logic              timeout_r;
  logic              hold_exp_s;

  assign hold_exp_s = (state_r == BUSY) && (hold_cnt_r == HOLD_LAST);
  assign release_s  = done || hold_exp_s;

  // Hold counter restarts on grant; timeout marks a forced release during the GAP cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt_r <= {HOLD_W{1'b0}};
      timeout_r  <= 1'b0;
    end else begin
      timeout_r <= hold_exp_s && !done;
      if (state_r == BUSY) begin
        hold_cnt_r <= hold_cnt_r + HOLD_W'(1);
      end else begin
        hold_cnt_r <= {HOLD_W{1'b0}};
      end
    end
  end

  assign timeout = timeout_r;
`else
  assign release_s = done;
`endif

  // Next-state and next-output logic for the IDLE/BUSY/GAP sequence.
  always_comb begin
    state_nxt_s     = state_r;
    gnt_nxt_s       = gnt_r;
    gnt_idx_nxt_s   = gnt_idx_r;
    gnt_valid_nxt_s = gnt_valid_r;
    ptr_nxt_s       = ptr_r;
    case (state_r)
      IDLE: begin
        if (pick_valid_s) begin
          gnt_nxt_s       = pick_onehot_s;
          gnt_idx_nxt_s   = pick_idx_s;
          gnt_valid_nxt_s = 1'b1;
          state_nxt_s     = BUSY;
        end else begin
          gnt_nxt_s       = {N_REQ{1'b0}};
          gnt_idx_nxt_s   = {IDX_W{1'b0}};
          gnt_valid_nxt_s = 1'b0;
        end
      end
      BUSY: begin
        if (release_s) begin
          gnt_nxt_s       = {N_REQ{1'b0}};
          gnt_idx_nxt_s   = {IDX_W{1'b0}};
          gnt_valid_nxt_s = 1'b0;
          ptr_nxt_s       = gnt_idx_r + IDX_W'(1);
          state_nxt_s     = GAP;
        end else begin
          state_nxt_s = BUSY;
        end
      end
      GAP: begin
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s     = IDLE;
        gnt_nxt_s       = {N_REQ{1'b0}};
        gnt_idx_nxt_s   = {IDX_W{1'b0}};
        gnt_valid_nxt_s = 1'b0;
      end
    endcase
  end

  // State, grant and pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      gnt_r       <= {N_REQ{1'b0}};
      gnt_idx_r   <= {IDX_W{1'b0}};
      gnt_valid_r <= 1'b0;
      ptr_r       <= {IDX_W{1'b0}};
    end else begin
      state_r     <= state_nxt_s;
      gnt_r       <= gnt_nxt_s;
      gnt_idx_r   <= gnt_idx_nxt_s;
      gnt_valid_r <= gnt_valid_nxt_s;
      ptr_r       <= ptr_nxt_s;
    end
  end

  assign gnt       = gnt_r;
  assign gnt_idx   = gnt_idx_r;
  assign gnt_valid = gnt_valid_r;
  assign ptr       = ptr_r;

endmodule

// File: tb/tb_rr_grant_scheduler.sv
// Directed self-checking bench for rr_grant_scheduler (N_REQ=8).
// With HOLD_TIMEOUT_EN defined it also covers the MAX_HOLD=4 timeout path.
module tb_rr_grant_scheduler;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic       done;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic [2:0] ptr;
`ifdef HOLD_TIMEOUT_EN
  logic       timeout;
`endif

  int n_assert;
  int n_fail;

  rr_grant_scheduler #(
    .N_REQ(8)
`ifdef HOLD_TIMEOUT_EN
    , .MAX_HOLD(4)
`endif
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .done     (done),
`ifdef HOLD_TIMEOUT_EN
    .timeout  (timeout),
`endif
    .gnt      (gnt),
    .gnt_idx  (gnt_idx),
    .gnt_valid(gnt_valid),
    .ptr      (ptr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Step negedges until a grant appears (bounded), check index/one-hot, then pulse done.
  task automatic grant_and_release(input string tag, input int exp_idx, input int exp_ptr);
    int cyc;
    cyc = 0;
    while (!gnt_valid && cyc < 6) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_valid"}, 32'(gnt_valid), 32'd1);
    chk({tag, "_idx"}, 32'(gnt_idx), 32'(exp_idx));
    chk({tag, "_gnt"}, 32'(gnt), 32'(8'd1 << exp_idx));
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    chk({tag, "_gap_gnt"}, 32'(gnt), 32'd0);
    chk({tag, "_ptr"}, 32'(ptr), 32'(exp_ptr));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    req      = 8'h00;
    done     = 1'b0;
    rst_n    = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_valid", 32'(gnt_valid), 32'd0);
    chk("rst_ptr", 32'(ptr), 32'd0);
    rst_n = 1'b1;

    // Single requester 2: one-cycle latency, ptr -> 3, GAP then IDLE both idle.
    req = 8'b0000_0100;
    @(negedge clk);
    chk("t1_gnt", 32'(gnt), 32'h04);
    chk("t1_idx", 32'(gnt_idx), 32'd2);
    chk("t1_valid", 32'(gnt_valid), 32'd1);
    chk("t1_ptr_busy", 32'(ptr), 32'd0);
    req  = 8'h00;
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    chk("t1_gap_gnt", 32'(gnt), 32'd0);
    chk("t1_ptr", 32'(ptr), 32'd3);
    @(negedge clk);
    chk("t1_idle_gnt", 32'(gnt), 32'd0);

    // All requesting from ptr=0: strict order 0..7 then 0.
    do_reset();
    chk("t2_ptr_rst", 32'(ptr), 32'd0);
    req = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      grant_and_release("t2", k % 8, (k + 1) % 8);
    end

    // Move ptr to 6 via requester 5, then wrap between 6 and 1.
    req = 8'h20;
    grant_and_release("t3_pre", 5, 6);
    req = 8'b0100_0010;
    grant_and_release("t3_a", 6, 7);
    grant_and_release("t3_b", 1, 2);
    grant_and_release("t3_c", 6, 7);

    // Owner 3 drops req while BUSY: grant holds; done in IDLE is ignored.
    req = 8'h08;
    @(negedge clk);
    @(negedge clk);
    chk("t4_gnt", 32'(gnt), 32'h08);
    req = 8'h00;
    repeat (3) @(negedge clk);
    chk("t4_hold_gnt", 32'(gnt), 32'h08);
    chk("t4_hold_idx", 32'(gnt_idx), 32'd3);
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    chk("t4_ptr", 32'(ptr), 32'd4);
    @(negedge clk);
    done = 1'b1;
    repeat (3) @(negedge clk);
    done = 1'b0;
    chk("t4_idle_done_gnt", 32'(gnt), 32'd0);
    chk("t4_idle_done_ptr", 32'(ptr), 32'd4);

    // Async reset mid-grant at idx 5, then regrant 5.
    req = 8'h20;
    @(negedge clk);
    @(negedge clk);
    chk("t5_idx", 32'(gnt_idx), 32'd5);
    rst_n = 1'b0;
    #1;
    chk("t5_async_gnt", 32'(gnt), 32'd0);
    chk("t5_async_valid", 32'(gnt_valid), 32'd0);
    chk("t5_async_ptr", 32'(ptr), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t5_regrant_idx", 32'(gnt_idx), 32'd5);
    chk("t5_regrant_valid", 32'(gnt_valid), 32'd1);
    req = 8'h00;

`ifdef HOLD_TIMEOUT_EN
    // MAX_HOLD=4 with no done: 4 BUSY cycles, timeout with GAP, ptr=1, regrant 0.
    do_reset();
    req = 8'h01;
    @(negedge clk);
    for (int c = 0; c < 4; c++) begin
      chk("t6_hold_gnt", 32'(gnt), 32'h01);
      chk("t6_hold_to", 32'(timeout), 32'd0);
      @(negedge clk);
    end
    chk("t6_to", 32'(timeout), 32'd1);
    chk("t6_gap_gnt", 32'(gnt), 32'd0);
    chk("t6_ptr", 32'(ptr), 32'd1);
    @(negedge clk);
    chk("t6_to_clear", 32'(timeout), 32'd0);
    @(negedge clk);
    chk("t6_regrant_idx", 32'(gnt_idx), 32'd0);
    chk("t6_regrant_valid", 32'(gnt_valid), 32'd1);
    req = 8'h00;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
